// File: rtl/lsu_axi_master.sv
// lsu_axi_master: bridges the load/store unit's request/response port onto an
// AXI-lite master (AR/R for loads, AW+W/B for stores). One transaction in
// flight at a time, one response per request, no bursts.
module lsu_axi_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,

    output logic [ADDR_W-1:0]     araddr,
    output logic                  arvalid,
    input  logic                  arready,

    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,

    output logic [ADDR_W-1:0]     awaddr,
    output logic                  awvalid,
    input  logic                  awready,

    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,

    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    // Request fields captured at accept; the read/write direction itself is
    // carried by which branch of the FSM we are in, so it needs no register.
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    // Write-side per-channel completion flags so AW and W may finish in any order.
    logic aw_done;
    logic w_done;

    // Address, data and strobe are driven straight from the capture registers
    // so they stay stable for the whole handshake.
    assign araddr = addr_q;
    assign awaddr = addr_q;
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;

    // State register with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and all handshake outputs decoded from the current state.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_wen ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    state_next = RESP;
                end
            end
            WR_REQ: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || awready) && (w_done || wready)) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture, write-channel completion tracking and response latching.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (awvalid && awready) begin
                aw_done <= 1'b1;
            end
            if (wvalid && wready) begin
                w_done <= 1'b1;
            end
            if (rready && rvalid) begin
                rsp_rdata <= rdata;
                rsp_err   <= (rresp != 2'b00);
            end
            if (bready && bvalid) begin
                rsp_rdata <= '0;
                rsp_err   <= (bresp != 2'b00);
            end
        end
    end

endmodule

// File: tb/tb_lsu_axi_master.sv
// tb_lsu_axi_master: drives LSU requests against a small AXI-lite slave model
// with programmable stalls and latencies, and checks responses from a queue of
// expected results plus AXI-side handshake records.
module tb_lsu_axi_master;

    logic        aclk;
    logic        aresetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] sl_rdata;
        logic [1:0]  sl_resp;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } resp_t;

    resp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rsp_hs = 0;

    // Slave model knobs and records
    logic [63:0] sl_rdata;
    logic [1:0]  sl_rresp;
    logic [1:0]  sl_bresp;
    int r_lat = 1;
    int b_lat = 1;
    int ar_stall = 0;
    int aw_stall = 0;
    int w_stall = 0;
    int ar_cnt = 0;
    int aw_cnt = 0;
    int w_cnt = 0;
    int aw_vcyc = 0;
    int w_vcyc = 0;
    logic [31:0] last_araddr;
    logic [31:0] last_awaddr;
    logic [63:0] last_wdata;
    logic [7:0]  last_wstrb;

    lsu_axi_master dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Cycle counter and response-handshake counter, sampled at the active edge.
    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (aresetn && rsp_valid && rsp_ready) rsp_hs <= rsp_hs + 1;
    end

    // AXI-lite slave: decides each ready/valid at the falling edge for the
    // rising edge that follows, logging every handshake it agrees to.
    initial begin
        int r_cnt;
        int b_cnt;
        bit r_pend;
        bit b_pend;
        bit r_hs;
        bit b_hs;
        bit aw_got;
        bit w_got;
        r_cnt = 0; b_cnt = 0; r_pend = 0; b_pend = 0; r_hs = 0; b_hs = 0;
        aw_got = 0; w_got = 0;
        arready = 0; rvalid = 0; rdata = '0; rresp = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
                r_pend = 0; b_pend = 0; r_hs = 0; b_hs = 0; aw_got = 0; w_got = 0;
            end else begin
                if (r_hs) begin rvalid = 0; r_hs = 0; end
                if (r_pend) begin
                    r_cnt--;
                    if (r_cnt <= 0) begin
                        r_pend = 0; rvalid = 1; rdata = sl_rdata; rresp = sl_rresp;
                    end
                end
                if (rvalid && rready) r_hs = 1;

                if (b_hs) begin bvalid = 0; b_hs = 0; end
                if (b_pend) begin
                    b_cnt--;
                    if (b_cnt <= 0) begin
                        b_pend = 0; bvalid = 1; bresp = sl_bresp;
                    end
                end
                if (bvalid && bready) b_hs = 1;

                if (arvalid) begin
                    if (ar_stall > 0) begin
                        arready = 0; ar_stall--;
                    end else begin
                        arready = 1; ar_cnt++; last_araddr = araddr;
                        r_pend = 1; r_cnt = r_lat;
                    end
                end else begin
                    arready = 0;
                end

                if (awvalid) aw_vcyc++;
                if (wvalid) w_vcyc++;
                if (awvalid) begin
                    if (aw_stall > 0) begin
                        awready = 0; aw_stall--;
                    end else begin
                        awready = 1; aw_cnt++; last_awaddr = awaddr; aw_got = 1;
                    end
                end else begin
                    awready = 0;
                end
                if (wvalid) begin
                    if (w_stall > 0) begin
                        wready = 0; w_stall--;
                    end else begin
                        wready = 1; w_cnt++; last_wdata = wdata; last_wstrb = wstrb; w_got = 1;
                    end
                end else begin
                    wready = 0;
                end
                if (aw_got && w_got) begin
                    aw_got = 0; w_got = 0; b_pend = 1; b_cnt = b_lat;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge: issues one request, checks latency, optional
    // response back-pressure, the popped response and the AXI-side traffic.
    task automatic applyStimulus(input vec_t v, input int rsp_hold, input int exp_lat);
        int n;
        int t_acc;
        int ar0;
        int aw0;
        int w0;
        resp_t exp;
        ar0 = ar_cnt; aw0 = aw_cnt; w0 = w_cnt;
        sl_rdata = v.sl_rdata; sl_rresp = v.sl_resp; sl_bresp = v.sl_resp;
        req_valid = 1; req_wen = v.wen; req_addr = v.addr;
        req_wdata = v.wdata; req_wstrb = v.wstrb;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge aclk); n++; end
        if (!req_ready) begin
            checkOutput("accept_timeout", 64'(req_ready), 64'd1);
            req_valid = 0;
            return;
        end
        t_acc = cyc;
        exp_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        @(negedge aclk);
        req_valid = 0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge aclk); n++; end
        if (!rsp_valid) begin
            checkOutput("rsp_timeout", 64'(rsp_valid), 64'd1);
            exp_q.delete();
            return;
        end
        checkOutput("latency", 64'(cyc - t_acc), 64'(exp_lat));
        for (int i = 0; i < rsp_hold; i++) begin
            @(negedge aclk);
            checkOutput("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            checkOutput("hold_rsp_rdata", rsp_rdata, exp_q[0].rdata);
            checkOutput("hold_req_ready", 64'(req_ready), 64'd0);
            checkOutput("hold_no_axi", 64'({arvalid, awvalid, wvalid}), 64'd0);
        end
        rsp_ready = 1;
        exp = exp_q.pop_front();
        checkOutput("rsp_rdata", rsp_rdata, exp.rdata);
        checkOutput("rsp_err", 64'(rsp_err), 64'(exp.err));
        checkOutput("resp_req_ready", 64'(req_ready), 64'd0);
        @(negedge aclk);
        rsp_ready = 0;
        checkOutput("rsp_valid_drop", 64'(rsp_valid), 64'd0);
        checkOutput("idle_req_ready", 64'(req_ready), 64'd1);
        if (v.wen) begin
            checkOutput("aw_count", 64'(aw_cnt - aw0), 64'd1);
            checkOutput("w_count", 64'(w_cnt - w0), 64'd1);
            checkOutput("ar_count_on_write", 64'(ar_cnt - ar0), 64'd0);
            checkOutput("awaddr", 64'(last_awaddr), 64'(v.addr));
            checkOutput("wdata", last_wdata, v.wdata);
            checkOutput("wstrb", 64'(last_wstrb), 64'(v.wstrb));
        end else begin
            checkOutput("ar_count", 64'(ar_cnt - ar0), 64'd1);
            checkOutput("aw_count_on_read", 64'(aw_cnt - aw0), 64'd0);
            checkOutput("araddr", 64'(last_araddr), 64'(v.addr));
        end
    endtask

    initial begin
        vec_t vecs[8];
        vec_t hv;
        int n;
        int hs0;

        vecs[0] = '{1'b0, 32'h8000_0008, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 2'b00, 64'h1122_3344_5566_7788, 1'b0};
        vecs[1] = '{1'b1, 32'h8000_0010, 64'hDEAD_BEEF, 8'h0F, 64'h0, 2'b00, 64'h0, 1'b0};
        vecs[2] = '{1'b1, 32'h8000_0018, 64'hCAFE_F00D_1234_5678, 8'hFF, 64'h0, 2'b10, 64'h0, 1'b1};
        vecs[3] = '{1'b0, 32'h8000_0020, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 64'h0102_0304_0506_0708, 2'b00, 64'h0102_0304_0506_0708, 1'b0};
        vecs[4] = '{1'b0, 32'h8000_0028, 64'h0, 8'h00, 64'hFFFF_0000_FFFF_0000, 2'b11, 64'hFFFF_0000_FFFF_0000, 1'b1};
        vecs[5] = '{1'b1, 32'h8000_0030, 64'h0123_4567_89AB_CDEF, 8'h00, 64'h0, 2'b00, 64'h0, 1'b0};
        vecs[6] = '{1'b1, 32'h8000_0038, 64'h5555_AAAA_5555_AAAA, 8'hF0, 64'h0, 2'b01, 64'h0, 1'b1};
        vecs[7] = '{1'b0, 32'hFFFF_FFF8, 64'h0, 8'h00, 64'h8000_0000_0000_0001, 2'b00, 64'h8000_0000_0000_0001, 1'b0};

        aresetn = 0; req_valid = 0; req_wen = 0; req_addr = '0; req_wdata = '0;
        req_wstrb = '0; rsp_ready = 0;
        sl_rdata = '0; sl_rresp = '0; sl_bresp = '0;
        repeat (3) @(negedge aclk);

        $display("[TB] reset state");
        checkOutput("rst_valids", 64'({arvalid, awvalid, wvalid, rready, bready, rsp_valid}), 64'd0);
        checkOutput("rst_rsp_err", 64'(rsp_err), 64'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 64'd0);
        checkOutput("rst_addr", 64'({araddr, awaddr}), 64'd0);
        checkOutput("rst_wdata", wdata, 64'd0);
        checkOutput("rst_wstrb", 64'(wstrb), 64'd0);
        aresetn = 1;
        @(negedge aclk);
        checkOutput("rst_req_ready", 64'(req_ready), 64'd1);

        $display("[TB] vector table");
        for (int i = 0; i < 8; i++) applyStimulus(vecs[i], 0, 3);

        $display("[TB] awready held low 3 cycles");
        hv = '{1'b1, 32'h8000_0100, 64'h1111_2222_3333_4444, 8'h3C, 64'h0, 2'b00, 64'h0, 1'b0};
        aw_vcyc = 0; w_vcyc = 0; aw_stall = 3; hs0 = rsp_hs;
        applyStimulus(hv, 0, 6);
        checkOutput("aw_valid_cycles", 64'(aw_vcyc), 64'd4);
        checkOutput("w_valid_cycles", 64'(w_vcyc), 64'd1);
        repeat (3) begin
            @(negedge aclk);
            checkOutput("no_extra_rsp", 64'(rsp_valid), 64'd0);
        end
        checkOutput("single_rsp", 64'(rsp_hs - hs0), 64'd1);

        $display("[TB] wready held low 2 cycles");
        hv = '{1'b1, 32'h8000_0108, 64'h9999_8888_7777_6666, 8'hC3, 64'h0, 2'b00, 64'h0, 1'b0};
        aw_vcyc = 0; w_vcyc = 0; w_stall = 2;
        applyStimulus(hv, 0, 5);
        checkOutput("aw_valid_cycles2", 64'(aw_vcyc), 64'd1);
        checkOutput("w_valid_cycles2", 64'(w_vcyc), 64'd3);

        $display("[TB] both write channels stalled 2 cycles");
        hv = '{1'b1, 32'h8000_0110, 64'h0F0F_0F0F_F0F0_F0F0, 8'h81, 64'h0, 2'b00, 64'h0, 1'b0};
        aw_vcyc = 0; w_vcyc = 0; aw_stall = 2; w_stall = 2;
        applyStimulus(hv, 0, 5);
        checkOutput("aw_valid_cycles3", 64'(aw_vcyc), 64'd3);
        checkOutput("w_valid_cycles3", 64'(w_vcyc), 64'd3);

        $display("[TB] rsp_ready held low 4 cycles");
        hv = '{1'b0, 32'h8000_0200, 64'h0, 8'h00, 64'hABCD_EF01_2345_6789, 2'b00, 64'hABCD_EF01_2345_6789, 1'b0};
        applyStimulus(hv, 4, 3);

        $display("[TB] reset while waiting for read data");
        r_lat = 5;
        sl_rdata = 64'h7777_7777_7777_7777; sl_rresp = 2'b00;
        req_valid = 1; req_wen = 0; req_addr = 32'h8000_0300;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge aclk); n++; end
        @(negedge aclk);
        req_valid = 0;
        n = 0;
        while (!rready && n < 20) begin @(negedge aclk); n++; end
        checkOutput("reach_rd_data", 64'(rready), 64'd1);
        aresetn = 0;
        @(negedge aclk);
        checkOutput("midrst_valids", 64'({arvalid, awvalid, wvalid, rready, bready, rsp_valid}), 64'd0);
        checkOutput("midrst_req_ready", 64'(req_ready), 64'd1);
        @(negedge aclk);
        aresetn = 1;
        r_lat = 1;
        hv = '{1'b0, 32'h8000_0308, 64'h0, 8'h00, 64'h0BAD_F00D_0000_0042, 2'b00, 64'h0BAD_F00D_0000_0042, 1'b0};
        applyStimulus(hv, 0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
